// File: rtl/tt_sweeper_pkg.sv
// tt_sweep_pkg: shared definitions for the truth-table sweeper.
//   - sweep_state_t : FSM state encoding used by tt_sweeper
//   - settle_cnt_w  : width of the settle down-counter for a given SETTLE
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // The counter holds values 0..SETTLE-1, so it needs clog2(SETTLE) bits,
  // with a floor of one bit for SETTLE of 1 or 2.
  function automatic int settle_cnt_w(input int settle);
    if (settle <= 2) return 1;
    return $clog2(settle);
  endfunction

endpackage

// File: rtl/tt_sweeper_if.sv
// tt_sweeper_if: control/observation bundle between a sweep controller and
// whatever drives it.
//   start, abort        : sweep control
//   exp_table           : expected DUT output, bit k for vector k
//   dut_o               : observed DUT output
//   vec                 : stimulus vector (MSB drives the first DUT input)
//   busy, done, pass    : status
//   err_cnt             : mismatch count
//   first_err_idx/_vld  : first mismatching vector
//   obs_table           : captured DUT outputs (only with TT_SWEEPER_CAPTURE_EN)
// Modports: master (drives control, reads status), slave (the sweeper).
interface tt_sweeper_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic                 abort;
  logic [2**N_IN-1:0]   exp_table;
  logic                 dut_o;
  logic [N_IN-1:0]      vec;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_cnt;
  logic [N_IN-1:0]      first_err_idx;
  logic                 first_err_vld;
`ifdef TT_SWEEPER_CAPTURE_EN
  logic [2**N_IN-1:0]   obs_table;
`endif

  modport master (
    output start, abort, exp_table, dut_o,
    input  vec, busy, done, pass, err_cnt, first_err_idx, first_err_vld
`ifdef TT_SWEEPER_CAPTURE_EN
    , input obs_table
`endif
  );

  modport slave (
    input  start, abort, exp_table, dut_o,
    output vec, busy, done, pass, err_cnt, first_err_idx, first_err_vld
`ifdef TT_SWEEPER_CAPTURE_EN
    , output obs_table
`endif
  );

endinterface

// File: rtl/tt_sweeper_settle_ctr.sv
// tt_settle_ctr: loadable down-counter timing how long each vector is held.
//   clk, rst_n : clock, async active-low reset
//   i_load     : load SETTLE-1 (start of a hold window)
//   i_en       : count down while holding
//   o_tc       : terminal count, high when the counter is at zero
// A load followed by SETTLE-1 enabled cycles reaches zero, so o_tc is seen
// on the SETTLE-th cycle of the hold window.
module tt_settle_ctr
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int           CNT_W    = settle_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/tt_sweeper.sv
// tt_sweeper: walks every input vector of an N_IN-input combinational DUT,
// holds each for SETTLE cycles, samples the DUT output, and compares it with
// the expected truth table.
//   clk, rst_n : clock, async active-low reset
//   sw_bus     : tt_sweeper_if.slave (start/abort/exp_table/dut_o in,
//                vec/busy/done/pass/err_cnt/first_err_* out)
// Build option TT_SWEEPER_CAPTURE_EN adds sw_bus.obs_table, the DUT output
// captured for every vector of the sweep.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start, vec parked at 0
// ST_APPLY  | vec driven, settle counter running
// ST_SAMPLE | one cycle: compare dut_o, step vec or finish
// ST_DONE   | one cycle: done pulse, pass valid
module tt_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  tt_sweeper_if.slave     sw_bus
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN:0]   ERR_MAX  = '1;
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

  sweep_state_t     r_state;
  logic [N_IN-1:0]  r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [N_IN:0]    r_err_cnt;
  logic [N_IN-1:0]  r_first_idx;
  logic             r_first_vld;

  logic             w_start_acc;
  logic             w_step;
  logic             w_ctr_load;
  logic             w_ctr_en;
  logic             w_tc;
  logic             w_mismatch;
  logic [N_IN:0]    w_err_next;

  assign w_start_acc = (r_state == ST_IDLE) && sw_bus.start;
  // A SAMPLE that is not aborted commits its comparison.
  assign w_step      = (r_state == ST_SAMPLE) && !sw_bus.abort;
  assign w_ctr_load  = w_start_acc || (w_step && (r_vec != LAST_VEC));
  assign w_ctr_en    = (r_state == ST_APPLY);

  assign w_mismatch  = (sw_bus.dut_o != sw_bus.exp_table[r_vec]);
  // Saturating increment; cannot actually reach ERR_MAX+1 but kept explicit.
  assign w_err_next  = (w_mismatch && (r_err_cnt != ERR_MAX)) ? (r_err_cnt + ERR_ONE)
                                                              : r_err_cnt;

  tt_settle_ctr #(
    .SETTLE (SETTLE)
  ) u_settle_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_ctr_load),
    .i_en   (w_ctr_en),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sw_bus.start) begin
            r_state     <= ST_APPLY;
            r_vec       <= '0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (sw_bus.abort) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (w_tc) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (sw_bus.abort) begin
            // Abort wins: this cycle's comparison is dropped.
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_err_cnt <= w_err_next;
            if (w_mismatch && !r_first_vld) begin
              r_first_idx <= r_vec;
              r_first_vld <= 1'b1;
            end
            if (r_vec == LAST_VEC) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_state <= ST_APPLY;
              r_vec   <= r_vec + VEC_ONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TT_SWEEPER_CAPTURE_EN
  logic [2**N_IN-1:0] r_obs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obs <= '0;
    end else if (w_start_acc) begin
      r_obs <= '0;
    end else if (w_step) begin
      r_obs[r_vec] <= sw_bus.dut_o;
    end
  end

  assign sw_bus.obs_table = r_obs;
`endif

  assign sw_bus.vec           = r_vec;
  assign sw_bus.busy          = r_busy;
  assign sw_bus.done          = r_done;
  assign sw_bus.pass          = r_pass;
  assign sw_bus.err_cnt       = r_err_cnt;
  assign sw_bus.first_err_idx = r_first_idx;
  assign sw_bus.first_err_vld = r_first_vld;

endmodule

// File: tb/tb_tt_sweeper.sv
module tb_tt_sweeper;

  localparam int N_IN   = 4;
  localparam int SETTLE = 2;
  localparam int NV     = 2**N_IN;

  localparam int MODE_AND    = 0;
  localparam int MODE_STUCK0 = 1;
  localparam int MODE_OR     = 2;
  localparam int MODE_XOR    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   mode  = MODE_AND;

  always #5 clk = ~clk;

  tt_sweeper_if #(.N_IN(N_IN)) sw_if ();

  tt_sweeper #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_bus (sw_if)
  );

  function automatic logic model_out(input int m, input logic [N_IN-1:0] v);
    case (m)
      MODE_AND:    return &v;
      MODE_STUCK0: return 1'b0;
      MODE_OR:     return |v;
      default:     return ^v;
    endcase
  endfunction

  always_comb sw_if.dut_o = model_out(mode, sw_if.vec);

  typedef struct {
    int             lat;
    int             errs;
    bit             vld;
    int             idx;
    bit             pass;
    logic [NV-1:0]  obs;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result of sweeping the first n_vec vectors.
  function automatic exp_t predict(input int m, input logic [NV-1:0] tbl, input int n_vec);
    exp_t e;
    logic o;
    e.lat  = NV*(SETTLE+1) + 1;
    e.errs = 0;
    e.vld  = 1'b0;
    e.idx  = 0;
    e.obs  = '0;
    for (int i = 0; i < n_vec; i++) begin
      o = model_out(m, N_IN'(i));
      e.obs[i] = o;
      if (o != tbl[i]) begin
        e.errs++;
        if (!e.vld) begin
          e.vld = 1'b1;
          e.idx = i;
        end
      end
    end
    e.pass = (e.errs == 0);
    return e;
  endfunction

  task automatic run_sweep(input int m, input logic [NV-1:0] tbl, input string name,
                           input bit poke_start);
    int   cnt;
    int   n_done;
    exp_t e;
    mode            = m;
    sw_if.exp_table = tbl;
    sb_q.push_back(predict(m, tbl, NV));
    sw_if.start = 1'b1;
    tick();
    cnt = 1;
    sw_if.start = 1'b0;
    while (!sw_if.done && cnt < 200) begin
      sw_if.start = poke_start && (cnt == 5 || cnt == 20 || cnt == 47);
      tick();
      cnt++;
    end
    sw_if.start = 1'b0;
    e = sb_q.pop_front();
    if (!sw_if.done) begin
      check_val({name, "_timeout"}, 32'(sw_if.done), 32'd1);
      return;
    end
    check_val({name, "_latency"}, 32'(cnt), 32'(e.lat));
    check_val({name, "_err_cnt"}, 32'(sw_if.err_cnt), 32'(e.errs));
    check_val({name, "_pass"}, 32'(sw_if.pass), 32'(e.pass));
    check_val({name, "_first_vld"}, 32'(sw_if.first_err_vld), 32'(e.vld));
    if (e.vld) check_val({name, "_first_idx"}, 32'(sw_if.first_err_idx), 32'(e.idx));
`ifdef TT_SWEEPER_CAPTURE_EN
    check_val({name, "_obs_table"}, 32'(sw_if.obs_table), 32'(e.obs));
`endif
    n_done = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (sw_if.done) n_done++;
    end
    check_val({name, "_done_pulses"}, 32'(n_done), 32'd1);
    check_val({name, "_busy_after"}, 32'(sw_if.busy), 32'd0);
    check_val({name, "_vec_idle"}, 32'(sw_if.vec), 32'd0);
    check_val({name, "_err_hold"}, 32'(sw_if.err_cnt), 32'(e.errs));
    check_val({name, "_pass_hold"}, 32'(sw_if.pass), 32'(e.pass));
  endtask

  task automatic abort_test();
    int   cnt;
    int   n_done;
    exp_t e;
    mode            = MODE_OR;
    sw_if.exp_table = 16'h8000;
    // Abort is sampled after ten cycles: vectors 0..2 have been compared.
    e = predict(MODE_OR, 16'h8000, 3);
    sw_if.start = 1'b1;
    tick();
    cnt = 1;
    sw_if.start = 1'b0;
    while (cnt < 10) begin
      tick();
      cnt++;
    end
    check_val("abort_busy_before", 32'(sw_if.busy), 32'd1);
    sw_if.abort = 1'b1;
    tick();
    sw_if.abort = 1'b0;
    check_val("abort_busy", 32'(sw_if.busy), 32'd0);
    check_val("abort_pass", 32'(sw_if.pass), 32'd0);
    check_val("abort_err_cnt", 32'(sw_if.err_cnt), 32'(e.errs));
    check_val("abort_first_vld", 32'(sw_if.first_err_vld), 32'(e.vld));
    check_val("abort_first_idx", 32'(sw_if.first_err_idx), 32'(e.idx));
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (sw_if.done) n_done++;
    end
    check_val("abort_no_done", 32'(n_done), 32'd0);
    check_val("abort_err_hold", 32'(sw_if.err_cnt), 32'(e.errs));
  endtask

  task automatic reset_mid_test();
    int n_done;
    mode            = MODE_OR;
    sw_if.exp_table = 16'h8000;
    sw_if.start = 1'b1;
    tick();
    sw_if.start = 1'b0;
    repeat (20) tick();
    check_val("rstmid_err_before", 32'(sw_if.err_cnt != '0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstmid_vec", 32'(sw_if.vec), 32'd0);
    check_val("rstmid_busy", 32'(sw_if.busy), 32'd0);
    check_val("rstmid_done", 32'(sw_if.done), 32'd0);
    check_val("rstmid_pass", 32'(sw_if.pass), 32'd0);
    check_val("rstmid_err_cnt", 32'(sw_if.err_cnt), 32'd0);
    check_val("rstmid_first_vld", 32'(sw_if.first_err_vld), 32'd0);
    check_val("rstmid_first_idx", 32'(sw_if.first_err_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (sw_if.done) n_done++;
    end
    check_val("rstmid_no_done", 32'(n_done), 32'd0);
    check_val("rstmid_busy_after", 32'(sw_if.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NV-1:0] rnd_tbl;
    sw_if.start     = 1'b0;
    sw_if.abort     = 1'b0;
    sw_if.exp_table = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vec", 32'(sw_if.vec), 32'd0);
    check_val("rst_busy", 32'(sw_if.busy), 32'd0);
    check_val("rst_done", 32'(sw_if.done), 32'd0);
    check_val("rst_pass", 32'(sw_if.pass), 32'd0);
    check_val("rst_err_cnt", 32'(sw_if.err_cnt), 32'd0);
    check_val("rst_first_vld", 32'(sw_if.first_err_vld), 32'd0);
    check_val("rst_first_idx", 32'(sw_if.first_err_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    run_sweep(MODE_AND,    16'h8000, "and4",   1'b0);
    run_sweep(MODE_STUCK0, 16'h8000, "stuck0", 1'b0);
    run_sweep(MODE_OR,     16'h8000, "or4",    1'b0);
    abort_test();
    run_sweep(MODE_OR,     16'h8000, "after_abort", 1'b0);
    reset_mid_test();
    run_sweep(MODE_AND,    16'h8000, "start_poke",  1'b1);
    run_sweep(MODE_XOR,    16'h6996, "xor4",        1'b0);
    rnd_tbl = NV'($urandom);
    run_sweep(MODE_XOR,    rnd_tbl,  "xor_rnd",     1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_sweeper.md
TT_SWEEPER -- requirements
Module: tt_sweeper

Interface
REQ-001 Parameter N_IN, default 4, number of DUT inputs (1..8).
REQ-002 Parameter SETTLE, default 2, cycles each vector is held before sampling (>=1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin sweep; sampled only in IDLE.
REQ-006 abort  input  1  synchronous sweep cancel.
REQ-007 exp_table  input  2**N_IN  expected output; bit k = expected dut_o for vector k.
REQ-008 dut_o  input  1  observed DUT output.
REQ-009 vec  output  N_IN  stimulus vector; vec[N_IN-1] drives the first DUT input (MSB).
REQ-010 busy  output  1  high in APPLY/SAMPLE.
REQ-011 done  output  1  one-cycle pulse at sweep end.
REQ-012 pass  output  1  last completed sweep had zero mismatches.
REQ-013 err_cnt  output  N_IN+1  mismatch count of current/last sweep.
REQ-014 first_err_idx  output  N_IN  vector index of first mismatch; first_err_vld  output  1  qualifies it.

Function
REQ-015 FSM states IDLE, APPLY, SAMPLE, DONE; encoding from tt_sweep_pkg.
REQ-016 IDLE and start=1: next cycle APPLY, vec=0, settle count=0, err_cnt=0, first_err_vld=0, pass=0.
REQ-017 APPLY holds vec for exactly SETTLE cycles, then SAMPLE.
REQ-018 SAMPLE (one cycle): dut_o != exp_table[vec] increments err_cnt; if first_err_vld=0, captures first_err_idx=vec and sets first_err_vld.
REQ-019 SAMPLE with vec != 2**N_IN-1: vec+1, back to APPLY; with vec = 2**N_IN-1: DONE, vec holds.
REQ-020 DONE (one cycle): done=1, pass=(final err_cnt==0), then IDLE; vec returns to 0 in IDLE.
REQ-021 Sweep latency start-to-done = 2**N_IN*(SETTLE+1)+1 cycles.
REQ-022 start in APPLY/SAMPLE/DONE ignored.
REQ-023 abort=1 in APPLY/SAMPLE: IDLE next cycle, no done pulse, pass=0, err_cnt/first_err_* hold; abort wins over SAMPLE update same cycle.
REQ-024 abort in IDLE/DONE ignored; DONE completes normally.
REQ-025 err_cnt never wraps (max 2**N_IN fits N_IN+1 bits).
REQ-026 pass, err_cnt, first_err_* hold after DONE until next accepted start.

Reset
REQ-027 rst_n low asynchronously forces IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, first_err_vld=0, settle count=0.
REQ-028 Reset mid-sweep discards the sweep; no done pulse.

Configuration
REQ-029 Macro TT_SWEEPER_CAPTURE_EN defined: extra output obs_table (2**N_IN bits), bit vec written with dut_o in each SAMPLE, cleared on accepted start and reset.
REQ-030 Macro undefined: obs_table port absent; no capture storage.

Structure
REQ-031 tt_sweep_pkg holds FSM state constants and the settle-counter width function.
REQ-032 Single sub-module tt_settle_ctr: loadable down-counter, SETTLE cycles, terminal-count flag to FSM.

Verification
REQ-033 N_IN=4, SETTLE=2, exp_table=16'h8000, DUT=AND4, start -> done at cycle 49, pass=1, err_cnt=0, first_err_vld=0.
REQ-034 Same, DUT stuck at 0 -> err_cnt=1, first_err_idx=15, pass=0.
REQ-035 exp_table=16'h8000, DUT=OR4 -> err_cnt=14, first_err_idx=1, pass=0.
REQ-036 abort 10 cycles after start -> busy=0 next cycle, no done, pass=0, then new start -> full sweep correct.
REQ-037 rst_n low mid-sweep -> all outputs reset immediately; start pulses during busy -> no restart, done once at cycle 49.
REQ-038 TT_SWEEPER_CAPTURE_EN, DUT=XOR4 -> obs_table=16'h6996 at done.
